// File: rtl/bus_decoder_pkg.sv
// Shared bus definitions: decoder FSM states, slave indices and the
// address-region nibbles that select each slave.
package bus_decoder_pkg;

    // Decoder transfer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RESPOND = 2'd2
    } bus_state_t;

    // Slave indices into the one-hot request / ready vectors
    localparam int NUM_SLAVES = 3;
    localparam int SLV_ROM    = 0;
    localparam int SLV_RAM    = 1;
    localparam int SLV_IO     = 2;

    // Value of address[31:28] that maps onto each slave
    localparam logic [3:0] REGION_ROM = 4'h0;
    localparam logic [3:0] REGION_RAM = 4'h2;
    localparam logic [3:0] REGION_IO  = 4'h5;

    // One-hot select vector for a slave index
    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input int idx);
        return NUM_SLAVES'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_address_map.sv
// Combinational address-region decode shared by bus blocks. Takes the top
// address nibble and returns a hit flag plus a one-hot slave select.
module bus_address_map
    import bus_decoder_pkg::*;
(
    input  logic [3:0]            i_region,
    output logic                  o_hit,
    output logic [NUM_SLAVES-1:0] o_select
);

    // Region nibble to one-hot slave; unmapped regions select nothing
    always_comb begin
        o_hit    = 1'b1;
        o_select = '0;
        case (i_region)
            REGION_ROM: o_select = slave_onehot(SLV_ROM);
            REGION_RAM: o_select = slave_onehot(SLV_RAM);
            REGION_IO:  o_select = slave_onehot(SLV_IO);
            default: begin
                o_hit    = 1'b0;
                o_select = '0;
            end
        endcase
    end

endmodule

// File: rtl/bus_decoder.sv
// Single-master to three-slave bus decoder with ready timeout.
//
// Handshake: the requester raises i_bus_request and holds it with stable
// address/data until it sees o_bus_ready; the decoder keeps o_bus_ready high
// in RESPOND for as long as i_bus_request stays high and returns to IDLE on the
// edge after the request is seen low. Towards the slaves, o_s_request is held
// on exactly one slave until that slave's i_s_ready is sampled high (or the
// timeout fires); ready bits of other slaves are ignored.
module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    // upstream (CPU side)
    input  logic                     i_bus_rw,
    input  logic                     i_bus_request,
    output logic                     o_bus_ready,
    input  logic [31:0]              i_bus_address,
    output logic [31:0]              o_bus_rdata,
    input  logic [31:0]              i_bus_wdata,
    input  logic [3:0]               i_bus_wmask,
    // slave side
    output logic [NUM_SLAVES-1:0]    o_s_request,
    input  logic [NUM_SLAVES-1:0]    i_s_ready,
    output logic                     o_s_rw,
    output logic [31:0]              o_s_address,
    output logic [31:0]              o_s_wdata,
    output logic [3:0]               o_s_wmask,
    input  logic [NUM_SLAVES*32-1:0] i_s_rdata,
    // error reporting
    output logic                     o_error,
    output logic [31:0]              o_fault_address,
    // debug view of the FSM state
    output logic [1:0]               o_dbg_state
);

    // Counter value of the last ACTIVE cycle allowed before abort
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    bus_state_t              r_state;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wmask;
    logic                    r_rw;
    logic [NUM_SLAVES-1:0]   r_select;
    logic [15:0]             r_count;
    logic [31:0]             r_rdata;
    logic                    r_error;
    logic [31:0]             r_fault_addr;

    bus_state_t              w_state_next;
    logic                    w_hit;
    logic [NUM_SLAVES-1:0]   w_select;
    logic                    w_sel_ready;
    logic [31:0]             w_sel_rdata;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_abort;
    logic                    w_count_en;
    logic                    w_err_set;

    bus_address_map u_map (
        .i_region (i_bus_address[31:28]),
        .o_hit    (w_hit),
        .o_select (w_select)
    );

    // Ready and read data of the registered target slave only
    always_comb begin
        w_sel_ready = |(i_s_ready & r_select);
        w_sel_rdata = '0;
        for (int n = 0; n < NUM_SLAVES; n++) begin
            if (r_select[n]) begin
                w_sel_rdata = w_sel_rdata | i_s_rdata[n*32 +: 32];
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_count_en   = 1'b0;
        o_s_request  = '0;
        o_bus_ready  = 1'b0;
        o_bus_rdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_bus_request) begin
                    w_accept     = 1'b1;
                    w_state_next = w_hit ? ST_ACTIVE : ST_RESPOND;
                end
            end
            ST_ACTIVE: begin
                o_s_request = r_select;
                if (w_sel_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_RESPOND;
                end else if (r_count == TIMEOUT_LAST) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_RESPOND;
                end else begin
                    w_count_en = 1'b1;
                end
            end
            ST_RESPOND: begin
                // A requester that already let go gets no ready: response dropped
                o_bus_ready = i_bus_request;
                o_bus_rdata = i_bus_request ? r_rdata : '0;
                if (!i_bus_request) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_err_set = (w_accept && !w_hit) || w_abort;
    end

    // Transfer registers, response data, timeout counter and error capture
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_rw         <= 1'b0;
            r_select     <= '0;
            r_count      <= '0;
            r_rdata      <= '0;
            r_error      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_error <= 1'b0;
            if (w_accept) begin
                r_addr   <= i_bus_address;
                r_wdata  <= i_bus_wdata;
                r_wmask  <= i_bus_wmask;
                r_rw     <= i_bus_rw;
                r_select <= w_select;
                r_count  <= '0;
                r_rdata  <= '0;
            end
            if (w_count_en) begin
                r_count <= r_count + 16'd1;
            end
            if (w_complete) begin
                r_rdata <= r_rw ? 32'h0 : w_sel_rdata;
            end
            if (w_err_set) begin
                r_error      <= 1'b1;
                r_fault_addr <= w_accept ? i_bus_address : r_addr;
            end
        end
    end

    assign o_s_rw          = r_rw;
    assign o_s_address     = r_addr;
    assign o_s_wdata       = r_wdata;
    assign o_s_wmask       = r_wmask;
    assign o_error         = r_error;
    assign o_fault_address = r_fault_addr;
    assign o_dbg_state     = r_state;

endmodule
